// File: rtl/softmax_bram_arbiter.sv
// Ownership arbiter and run sequencer for the softmax working BRAM (A=write, B=read).
// Latency: grant is combinational, BRAM ports registered (+1), read return at +1+RD_LAT; requesters are held off by grant=0.
module softmax_bram_arbiter #(
  parameter int DW     = 1028,
  parameter int AW     = 5,
  parameter int RD_LAT = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_core_done,
  output logic          o_core_start,
  output logic          o_busy,
  input  logic          i_err_clr,
  output logic          o_host_err,
  output logic [7:0]    o_rej_cnt,
  input  logic          i_h_a_req,
  input  logic          i_h_a_we,
  input  logic [AW-1:0] i_h_a_addr,
  input  logic [DW-1:0] i_h_a_din,
  output logic          o_h_a_gnt,
  input  logic          i_h_b_req,
  input  logic [AW-1:0] i_h_b_addr,
  output logic          o_h_b_gnt,
  output logic          o_h_b_rvalid,
  output logic [DW-1:0] o_h_b_rdata,
  input  logic          i_c_a_req,
  input  logic          i_c_a_we,
  input  logic [AW-1:0] i_c_a_addr,
  input  logic [DW-1:0] i_c_a_din,
  output logic          o_c_a_gnt,
  input  logic          i_c_b_req,
  input  logic [AW-1:0] i_c_b_addr,
  output logic          o_c_b_gnt,
  output logic          o_c_b_rvalid,
  output logic [DW-1:0] o_c_b_rdata,
  output logic          o_m_a_en,
  output logic          o_m_a_we,
  output logic [AW-1:0] o_m_a_addr,
  output logic [DW-1:0] o_m_a_din,
  output logic          o_m_b_en,
  output logic [AW-1:0] o_m_b_addr,
  input  logic [DW-1:0] i_m_b_dout
);

  typedef enum logic [1:0] {
    ST_HOST    = 2'd0,
    ST_ARM     = 2'd1,
    ST_CORE    = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            core_start_q, core_start_d;
  logic            host_err_q, host_err_d;
  logic [7:0]      rej_cnt_q, rej_cnt_d;
  logic            m_a_en_q, m_a_en_d;
  logic            m_a_we_q, m_a_we_d;
  logic [AW-1:0]   m_a_addr_q, m_a_addr_d;
  logic [DW-1:0]   m_a_din_q, m_a_din_d;
  logic            m_b_en_q, m_b_en_d;
  logic [AW-1:0]   m_b_addr_q, m_b_addr_d;
  logic [RD_LAT:0] tag_vld_q, tag_vld_d;
  logic [RD_LAT:0] tag_host_q, tag_host_d;

  logic host_own, core_own;
  logic h_a_gnt, h_b_gnt, c_a_gnt, c_b_gnt;
  logic host_rd_pend, core_rd_pend;
  logic host_rej;
  logic h_rvld, c_rvld;

  always_comb begin
    host_own = (state_q == ST_HOST);
    core_own = (state_q == ST_CORE);
    h_a_gnt  = i_h_a_req & host_own;
    h_b_gnt  = i_h_b_req & host_own;
    c_a_gnt  = i_c_a_req & core_own;
    c_b_gnt  = i_c_b_req & core_own;
    host_rej = (i_h_a_req | i_h_b_req) & ~host_own;
  end

  // The last tag stage is returning this cycle, so it no longer blocks a handover.
  always_comb begin
    host_rd_pend = 1'b0;
    core_rd_pend = 1'b0;
    for (int i = 0; i < RD_LAT; i++) begin
      host_rd_pend = host_rd_pend | (tag_vld_q[i] & tag_host_q[i]);
      core_rd_pend = core_rd_pend | (tag_vld_q[i] & ~tag_host_q[i]);
    end
  end

  always_comb begin
    state_d      = state_q;
    core_start_d = 1'b0;
    case (state_q)
      ST_HOST: begin
        if (i_start) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (!host_rd_pend) begin
          state_d      = ST_CORE;
          core_start_d = 1'b1;
        end
      end
      ST_CORE: begin
        if (i_core_done) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!core_rd_pend) state_d = ST_HOST;
      end
      default: state_d = ST_HOST;
    endcase
  end

  always_comb begin
    host_err_d = host_err_q;
    rej_cnt_d  = rej_cnt_q;
    if (i_err_clr) begin
      host_err_d = 1'b0;
      rej_cnt_d  = 8'd0;
    end else if (host_rej) begin
      host_err_d = 1'b1;
      if (rej_cnt_q != 8'hFF) rej_cnt_d = rej_cnt_q + 8'd1;
    end
  end

  always_comb begin
    m_a_en_d   = h_a_gnt | c_a_gnt;
    m_a_we_d   = (h_a_gnt & i_h_a_we) | (c_a_gnt & i_c_a_we);
    m_a_addr_d = m_a_addr_q;
    m_a_din_d  = m_a_din_q;
    if (h_a_gnt) begin
      m_a_addr_d = i_h_a_addr;
      m_a_din_d  = i_h_a_din;
    end else if (c_a_gnt) begin
      m_a_addr_d = i_c_a_addr;
      m_a_din_d  = i_c_a_din;
    end
  end

  always_comb begin
    m_b_en_d   = h_b_gnt | c_b_gnt;
    m_b_addr_d = m_b_addr_q;
    if (h_b_gnt) begin
      m_b_addr_d = i_h_b_addr;
    end else if (c_b_gnt) begin
      m_b_addr_d = i_c_b_addr;
    end
    tag_vld_d  = {tag_vld_q[RD_LAT-1:0], h_b_gnt | c_b_gnt};
    tag_host_d = {tag_host_q[RD_LAT-1:0], h_b_gnt};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_HOST;
      core_start_q <= 1'b0;
      host_err_q   <= 1'b0;
      rej_cnt_q    <= 8'd0;
      m_a_en_q     <= 1'b0;
      m_a_we_q     <= 1'b0;
      m_a_addr_q   <= '0;
      m_a_din_q    <= '0;
      m_b_en_q     <= 1'b0;
      m_b_addr_q   <= '0;
      tag_vld_q    <= '0;
      tag_host_q   <= '0;
    end else begin
      state_q      <= state_d;
      core_start_q <= core_start_d;
      host_err_q   <= host_err_d;
      rej_cnt_q    <= rej_cnt_d;
      m_a_en_q     <= m_a_en_d;
      m_a_we_q     <= m_a_we_d;
      m_a_addr_q   <= m_a_addr_d;
      m_a_din_q    <= m_a_din_d;
      m_b_en_q     <= m_b_en_d;
      m_b_addr_q   <= m_b_addr_d;
      tag_vld_q    <= tag_vld_d;
      tag_host_q   <= tag_host_d;
    end
  end

  // Read data is steered by the issuer tag, never by the current owner.
  assign h_rvld = tag_vld_q[RD_LAT] & tag_host_q[RD_LAT];
  assign c_rvld = tag_vld_q[RD_LAT] & ~tag_host_q[RD_LAT];

  assign o_h_a_gnt    = h_a_gnt;
  assign o_h_b_gnt    = h_b_gnt;
  assign o_c_a_gnt    = c_a_gnt;
  assign o_c_b_gnt    = c_b_gnt;
  assign o_h_b_rvalid = h_rvld;
  assign o_c_b_rvalid = c_rvld;
  assign o_h_b_rdata  = h_rvld ? i_m_b_dout : '0;
  assign o_c_b_rdata  = c_rvld ? i_m_b_dout : '0;
  assign o_core_start = core_start_q;
  assign o_busy       = (state_q != ST_HOST);
  assign o_host_err   = host_err_q;
  assign o_rej_cnt    = rej_cnt_q;
  assign o_m_a_en     = m_a_en_q;
  assign o_m_a_we     = m_a_we_q;
  assign o_m_a_addr   = m_a_addr_q;
  assign o_m_a_din    = m_a_din_q;
  assign o_m_b_en     = m_b_en_q;
  assign o_m_b_addr   = m_b_addr_q;

endmodule

// File: tb/tb_softmax_bram_arbiter.sv
// Bench for softmax_bram_arbiter: random host/core traffic against a queue-based
// ownership and read-return model, with a behavioural BRAM attached to the memory ports.
module tb_softmax_bram_arbiter;
  localparam int DW     = 1028;
  localparam int AW     = 5;
  localparam int RD_LAT = 1;
  localparam int NW     = 1 << AW;
  localparam int S_HOST = 0, S_ARM = 1, S_CORE = 2, S_REL = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, core_done, err_clr;
  logic          core_start, busy, host_err;
  logic [7:0]    rej_cnt;
  logic          h_a_req, h_a_we, h_a_gnt, h_b_req, h_b_gnt, h_rvalid;
  logic [AW-1:0] h_a_addr, h_b_addr;
  logic [DW-1:0] h_a_din, h_rdata;
  logic          c_a_req, c_a_we, c_a_gnt, c_b_req, c_b_gnt, c_rvalid;
  logic [AW-1:0] c_a_addr, c_b_addr;
  logic [DW-1:0] c_a_din, c_rdata;
  logic          m_a_en, m_a_we, m_b_en;
  logic [AW-1:0] m_a_addr, m_b_addr;
  logic [DW-1:0] m_a_din, m_b_dout;

  softmax_bram_arbiter #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_core_done(core_done),
    .o_core_start(core_start), .o_busy(busy), .i_err_clr(err_clr),
    .o_host_err(host_err), .o_rej_cnt(rej_cnt),
    .i_h_a_req(h_a_req), .i_h_a_we(h_a_we), .i_h_a_addr(h_a_addr), .i_h_a_din(h_a_din),
    .o_h_a_gnt(h_a_gnt), .i_h_b_req(h_b_req), .i_h_b_addr(h_b_addr), .o_h_b_gnt(h_b_gnt),
    .o_h_b_rvalid(h_rvalid), .o_h_b_rdata(h_rdata),
    .i_c_a_req(c_a_req), .i_c_a_we(c_a_we), .i_c_a_addr(c_a_addr), .i_c_a_din(c_a_din),
    .o_c_a_gnt(c_a_gnt), .i_c_b_req(c_b_req), .i_c_b_addr(c_b_addr), .o_c_b_gnt(c_b_gnt),
    .o_c_b_rvalid(c_rvalid), .o_c_b_rdata(c_rdata),
    .o_m_a_en(m_a_en), .o_m_a_we(m_a_we), .o_m_a_addr(m_a_addr), .o_m_a_din(m_a_din),
    .o_m_b_en(m_b_en), .o_m_b_addr(m_b_addr), .i_m_b_dout(m_b_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < (DW + 31) / 32; i++) w = {w[DW-33:0], 32'($urandom)};
    return w;
  endfunction

  // Behavioural BRAM: read-first, RD_LAT cycles; junk on dout when not reading.
  logic [DW-1:0] bmem  [NW];
  logic [DW-1:0] bpipe [RD_LAT];
  always @(posedge clk) begin
    if (m_a_en && m_a_we) bmem[m_a_addr] <= m_a_din;
    bpipe[0] <= m_b_en ? bmem[m_b_addr] : rand_word();
    for (int i = 1; i < RD_LAT; i++) bpipe[i] <= bpipe[i-1];
  end
  assign m_b_dout = bpipe[RD_LAT-1];

  // Reference model: owner state, memory image and a queue of pending read returns.
  typedef struct {
    int            due;
    bit            host;
    logic [DW-1:0] data;
  } ret_t;

  ret_t          rq[$];
  logic [DW-1:0] ref_mem [NW];
  int            m_st;
  bit            e_cstart, e_err;
  int            e_cnt;
  bit            e_a_en, e_a_we, e_b_en;
  logic [AW-1:0] e_a_addr, e_b_addr;
  logic [DW-1:0] e_a_din;
  int            cyc;
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, obs[127:0], exp[127:0]);
    end
  endtask

  task automatic model_reset();
    m_st = S_HOST;
    rq.delete();
    e_cstart = 0; e_err = 0; e_cnt = 0;
    e_a_en = 0; e_a_we = 0; e_b_en = 0;
    e_a_addr = '0; e_b_addr = '0; e_a_din = '0;
  endtask

  task automatic chk_zero();
    chk("rst_h_a_gnt", h_a_gnt, 0);   chk("rst_h_b_gnt", h_b_gnt, 0);
    chk("rst_c_a_gnt", c_a_gnt, 0);   chk("rst_c_b_gnt", c_b_gnt, 0);
    chk("rst_m_a_en", m_a_en, 0);     chk("rst_m_a_we", m_a_we, 0);
    chk("rst_m_a_addr", m_a_addr, 0); chk("rst_m_a_din", m_a_din, 0);
    chk("rst_m_b_en", m_b_en, 0);     chk("rst_m_b_addr", m_b_addr, 0);
    chk("rst_h_rvalid", h_rvalid, 0); chk("rst_c_rvalid", c_rvalid, 0);
    chk("rst_h_rdata", h_rdata, 0);   chk("rst_c_rdata", c_rdata, 0);
    chk("rst_core_start", core_start, 0); chk("rst_busy", busy, 0);
    chk("rst_host_err", host_err, 0); chk("rst_rej_cnt", rej_cnt, 0);
  endtask

  task automatic idle();
    start = 0; core_done = 0; err_clr = 0;
    h_a_req = 0; h_a_we = 0; h_b_req = 0; c_a_req = 0; c_a_we = 0; c_b_req = 0;
    h_a_addr = AW'($urandom); h_b_addr = AW'($urandom);
    c_a_addr = AW'($urandom); c_b_addr = AW'($urandom);
    h_a_din = rand_word(); c_a_din = rand_word();
  endtask

  function automatic bit pct(input int p);
    return $urandom_range(99) < p;
  endfunction

  task automatic drive_rand(input int ph, input int pc, input int ps, input int pd, input int pclr);
    idle();
    h_a_req = pct(ph); h_a_we = pct(50); h_b_req = pct(ph);
    c_a_req = pct(pc); c_a_we = pct(50); c_b_req = pct(pc);
    start = pct(ps); core_done = pct(pd); err_clr = pct(pclr);
  endtask

  // One clock: compare every output at the falling edge, then advance the model.
  task automatic tick();
    bit hag, hbg, cag, cbg, e_hrv, e_crv, pend_h, pend_c;
    logic [DW-1:0] e_hrd, e_crd;
    ret_t r;
    @(negedge clk);
    hag = h_a_req && (m_st == S_HOST);
    hbg = h_b_req && (m_st == S_HOST);
    cag = c_a_req && (m_st == S_CORE);
    cbg = c_b_req && (m_st == S_CORE);
    e_hrv = 0; e_crv = 0; e_hrd = '0; e_crd = '0;
    foreach (rq[i]) begin
      if (rq[i].due == cyc) begin
        if (rq[i].host) begin e_hrv = 1; e_hrd = rq[i].data; end
        else begin e_crv = 1; e_crd = rq[i].data; end
      end
    end
    chk("h_a_gnt", h_a_gnt, hag);     chk("h_b_gnt", h_b_gnt, hbg);
    chk("c_a_gnt", c_a_gnt, cag);     chk("c_b_gnt", c_b_gnt, cbg);
    chk("m_a_en", m_a_en, e_a_en);    chk("m_a_we", m_a_we, e_a_we);
    chk("m_a_addr", m_a_addr, e_a_addr); chk("m_a_din", m_a_din, e_a_din);
    chk("m_b_en", m_b_en, e_b_en);    chk("m_b_addr", m_b_addr, e_b_addr);
    chk("h_rvalid", h_rvalid, e_hrv); chk("c_rvalid", c_rvalid, e_crv);
    chk("h_rdata", h_rdata, e_hrd);   chk("c_rdata", c_rdata, e_crd);
    chk("core_start", core_start, e_cstart);
    chk("busy", busy, m_st != S_HOST);
    chk("host_err", host_err, e_err); chk("rej_cnt", rej_cnt, e_cnt[7:0]);

    if (hbg || cbg) begin
      r.due  = cyc + 1 + RD_LAT;
      r.host = hbg;
      r.data = ref_mem[hbg ? h_b_addr : c_b_addr];
      rq.push_back(r);
    end
    if (hag && h_a_we) ref_mem[h_a_addr] = h_a_din;
    if (cag && c_a_we) ref_mem[c_a_addr] = c_a_din;
    e_a_en = hag || cag;
    e_a_we = (hag && h_a_we) || (cag && c_a_we);
    if (hag) begin e_a_addr = h_a_addr; e_a_din = h_a_din; end
    else if (cag) begin e_a_addr = c_a_addr; e_a_din = c_a_din; end
    e_b_en = hbg || cbg;
    if (hbg) e_b_addr = h_b_addr;
    else if (cbg) e_b_addr = c_b_addr;

    while (rq.size() > 0 && rq[0].due <= cyc) void'(rq.pop_front());
    pend_h = 0; pend_c = 0;
    foreach (rq[i]) begin
      if (rq[i].host) pend_h = 1; else pend_c = 1;
    end
    e_cstart = 0;
    case (m_st)
      S_HOST: if (start) m_st = S_ARM;
      S_ARM:  if (!pend_h) begin m_st = S_CORE; e_cstart = 1; end
      S_CORE: if (core_done) m_st = S_REL;
      default: if (!pend_c) m_st = S_HOST;
    endcase
    if (err_clr) begin
      e_err = 0; e_cnt = 0;
    end else if ((h_a_req || h_b_req) && !(hag || hbg || (m_st == S_HOST && !start && 0))) begin
      if (!(hag || hbg)) begin
        e_err = 1;
        if (e_cnt < 255) e_cnt++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto_core();
    for (int i = 0; i < 400; i++) begin
      if (m_st == S_CORE) break;
      drive_rand(20, 20, 50, 0, 0);
      tick();
    end
    chk("reach_core_busy", busy, 1);
  endtask

  initial begin
    cyc = 0;
    rst_n = 0;
    idle();
    model_reset();
    #3;
    chk_zero();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;

    // Fill the memory from the host so every later read has a known value.
    for (int a = 0; a < NW; a++) begin
      idle(); h_a_req = 1; h_a_we = 1; h_a_addr = AW'(a);
      tick();
    end
    idle(); h_b_req = 1; h_b_addr = 3; tick();

    // Handover with a host read issued in the same cycle as start.
    idle(); h_b_req = 1; h_b_addr = 3; start = 1; tick();
    idle(); h_a_req = 1; tick();
    for (int i = 0; i < 3; i++) begin idle(); tick(); end

    // Core fills the memory, reads back, then finishes with a read in flight.
    for (int a = 0; a < NW; a++) begin
      idle(); c_a_req = 1; c_a_we = 1; c_a_addr = AW'(a); h_b_req = (a == 5);
      tick();
    end
    idle(); c_b_req = 1; c_b_addr = 31; tick();
    for (int i = 0; i < 3; i++) begin idle(); tick(); end
    idle(); err_clr = 1; tick();
    idle(); c_b_req = 1; c_b_addr = 7; core_done = 1; tick();
    idle(); h_b_req = 1; start = 0; tick();
    for (int i = 0; i < 3; i++) begin idle(); h_a_req = 1; h_a_we = 1; h_a_addr = AW'(i); tick(); end

    for (int i = 0; i < 1500; i++) begin
      drive_rand(35, 50, 8, 5, 3);
      tick();
    end

    // Long core run with host requesting every cycle: counter must saturate.
    goto_core();
    for (int i = 0; i < 300; i++) begin
      drive_rand(0, 50, 30, 0, 0);
      h_a_req = 1;
      tick();
    end
    chk("rej_sat", rej_cnt, 255);
    idle(); err_clr = 1; h_b_req = 1; tick();
    idle(); core_done = 1; tick();
    for (int i = 0; i < 4; i++) begin idle(); start = (i == 1) ? 0 : 0; core_done = 1; tick(); end

    // Reset in the middle of a core run with a read outstanding.
    goto_core();
    idle(); c_b_req = 1; tick();
    rst_n = 0;
    #1;
    chk_zero();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin idle(); tick(); end

    for (int i = 0; i < 500; i++) begin
      drive_rand(35, 50, 8, 5, 3);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
